sr_pulse_gen: RTL
=================

Name: sr_pulse_gen

Overview:
- Upstream driver for the SR latch stage. Takes two raw push-button inputs, set and reset.
- Synchronises and debounces each button, then turns each debounced press into a clean, fixed-width pulse on s or r.
- Guarantees the latch never receives s=r=1, and spaces pulses so the latch always sees a 00 hold cycle between commands.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples needed to accept a new button level (must be >= 2).
- PULSE_CYCLES, 2, width of each s or r pulse in clock cycles (must be >= 1).
- RESET_PRIORITY, 1, 1 = reset wins a set/reset conflict; 0 = set wins.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- btn_set  input  1  raw set button, asynchronous to clk, may bounce.
- btn_reset  input  1  raw reset button, asynchronous to clk, may bounce.
- s  output  1  registered set pulse to the latch.
- r  output  1  registered reset pulse to the latch.
- busy  output  1  high while a pulse or its gap cycle is in progress.
- conflict  output  1  one-cycle flag when set and reset requests are both pending in IDLE.
- set_db  output  1  debounced set button level.
- reset_db  output  1  debounced reset button level.

Behaviour:
Interface (already decided):
- One clock, clk.
- Reset rst_n is asynchronous and active-low.
- While rst_n=0, all flops clear immediately, independent of clk.
- Reset values: s=0, r=0, busy=0, conflict=0, set_db=0, reset_db=0, synchronisers 0, debounce counters 0, pending flags 0, FSM=IDLE.

Synchroniser:
- Two flops per button; the second flop's output is the "sync" level.

Debounce (per channel):
- Counter cnt runs from 0 to DEBOUNCE_CYCLES-1.
- If sync == db: cnt <= 0.
- If sync != db and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
- If sync != db and cnt == DEBOUNCE_CYCLES-1: db <= sync, cnt <= 0.
- A glitch shorter than DEBOUNCE_CYCLES synchronised samples never changes db.
- Counter width is ceil(log2(DEBOUNCE_CYCLES)), with a minimum of 1.

Request capture:
- Detect a rising edge of db (db=1, previous db=0). Falling edges produce nothing.
- A rising edge sets the channel's pending flag. A second edge while already pending merges into the same flag (one-deep).
- Pending flags are set in the same cycle the FSM clears them, so no request is lost.

FSM states: IDLE, SET_P, RST_P, GAP.
- IDLE, only pend_set: go to SET_P, clear pend_set.
- IDLE, only pend_reset: go to RST_P, clear pend_reset.
- IDLE, both pending: the priority winner's pulse state is entered. Both flags are cleared (loser dropped). conflict=1 for exactly that cycle.
- SET_P / RST_P: hold for PULSE_CYCLES cycles using a pulse counter, then go to GAP.
- GAP: one cycle with s=r=0, then return to IDLE.
- Requests arriving during SET_P, RST_P or GAP stay pending and are serviced from IDLE in arrival order. If both are pending at IDLE, the priority rule applies.

Outputs:
- s=1 exactly in SET_P; r=1 exactly in RST_P. Both are registered.
- busy=1 in SET_P, RST_P and GAP.
- Invariant: s & r == 0 in every cycle.

Latency:
- s (or r) rises exactly DEBOUNCE_CYCLES+4 rising edges after the first edge that samples the button high.
- Breakdown: 2 synchroniser edges, DEBOUNCE_CYCLES filter edges, 1 pending-register edge, 1 FSM edge.
- Default latency is 8 edges.

Back-to-back pulses:
- Minimum spacing between the start of two consecutive pulses is PULSE_CYCLES+2 cycles (pulse, GAP, IDLE).

Reset mid-pulse:
- s and r drop to 0 asynchronously.
- Any pending request is discarded.
- A button still held after rst_n deasserts is seen as a new press (db starts at 0) and produces one pulse after the full latency.

Test Plan:
- Reset then clean press: btn_set held high from edge 1 -> set_db rises at edge 6; s=1 at edges 8-9; s=0 at edge 10; busy high edges 8-10; r stays 0 throughout.
- Bouncy press: btn_reset toggles 1,0,1,0 on single cycles, then holds 1 -> no r pulse during bouncing; exactly one 2-cycle r pulse, 8 edges after the final stable rise.
- Glitch rejection: btn_set high for 3 cycles, then low -> set_db stays 0; s never asserted.
- Simultaneous press: both buttons rise on the same edge, RESET_PRIORITY=1 -> conflict=1 for one cycle; one r pulse only; s stays 0. Repeat with RESET_PRIORITY=0 -> one s pulse only.
- Queued request: btn_reset debounces while the s pulse is active -> s pulse, GAP cycle, IDLE, then r pulse. Pulse starts are 4 cycles apart; s&r==0 in every cycle.
- Reset mid-pulse: assert rst_n=0 during the first s cycle while btn_set is held -> s=0 immediately. After release, s pulses again 8 edges after the first sampled edge.

Source files
------------

// File: rtl/sr_pulse_gen_if.sv
// sr_pulse_gen_if: button inputs and latch-side outputs
// of the SR pulse generator.
interface sr_pulse_gen_if;
  logic btn_set;
  logic btn_reset;
  logic s;
  logic r;
  logic busy;
  logic conflict;
  logic set_db;
  logic reset_db;

  modport master (
    input  btn_set,
    input  btn_reset,
    output s,
    output r,
    output busy,
    output conflict,
    output set_db,
    output reset_db
  );

  modport slave (
    output btn_set,
    output btn_reset,
    input  s,
    input  r,
    input  busy,
    input  conflict,
    input  set_db,
    input  reset_db
  );
endinterface

// File: rtl/sr_pulse_gen.sv
// sr_pulse_gen: syncs and debounces two buttons, emits
// non-overlapping fixed-width s/r pulses with a gap cycle.
module sr_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_CYCLES    = 2,
  parameter bit RESET_PRIORITY  = 1'b1
) (
  input logic            clk,
  input logic            rst_n,
  sr_pulse_gen_if.master bus
);
  localparam int CW =
    (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PW =
    (PULSE_CYCLES > 2) ? $clog2(PULSE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX =
    CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PLS_MAX =
    PW'(PULSE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE, SET_P, RST_P, GAP
  } state_t;

  // bit 0 = set channel, bit 1 = reset channel
  logic [1:0]    btn;
  logic [1:0]    meta;
  logic [1:0]    sync;
  logic [1:0]    db;
  logic [1:0]    db_q;
  logic [1:0]    pend;
  logic [1:0]    rise;
  logic [1:0]    clr;
  logic [CW-1:0] cnt [2];
  logic          win_set;
  logic          win_rst;
  state_t        state;
  logic [PW-1:0] pcnt;
  logic          s_q;
  logic          r_q;
  logic          busy_q;
  logic          conf_q;

  assign btn = {bus.btn_reset, bus.btn_set};

  // two-flop synchroniser per button
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= btn;
      sync <= meta;
    end
  end

  // accept a new level only after enough disagreeing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db <= '0;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          db[i]  <= sync[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  assign rise = db & ~db_q;
  // IDLE consumes whatever is pending; a loser is dropped
  assign clr  = (state == IDLE) ? pend : 2'b00;

  assign win_set = pend[0] &
    (~pend[1] | ~RESET_PRIORITY);
  assign win_rst = pend[1] &
    (~pend[0] | RESET_PRIORITY);

  // one-deep request flags; a new edge survives a clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_q <= '0;
      pend <= '0;
    end else begin
      db_q <= db;
      pend <= (pend & ~clr) | rise;
    end
  end

  // pulse sequencer with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pcnt   <= '0;
      s_q    <= 1'b0;
      r_q    <= 1'b0;
      busy_q <= 1'b0;
      conf_q <= 1'b0;
    end else begin
      conf_q <= 1'b0;
      case (state)
        IDLE: begin
          conf_q <= pend[0] & pend[1];
          pcnt   <= '0;
          unique case (1'b1)
            win_set: begin
              state  <= SET_P;
              s_q    <= 1'b1;
              busy_q <= 1'b1;
            end
            win_rst: begin
              state  <= RST_P;
              r_q    <= 1'b1;
              busy_q <= 1'b1;
            end
            default: ;
          endcase
        end
        SET_P, RST_P: begin
          if (pcnt == PLS_MAX) begin
            state <= GAP;
            s_q   <= 1'b0;
            r_q   <= 1'b0;
          end else begin
            pcnt <= pcnt + PW'(1);
          end
        end
        GAP: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.s        = s_q;
  assign bus.r        = r_q;
  assign bus.busy     = busy_q;
  assign bus.conflict = conf_q;
  assign bus.set_db   = db[0];
  assign bus.reset_db = db[1];
endmodule
